// File: rtl/serial_adder_subtractor.sv
// serial_adder_subtractor: digit-serial two's complement adder/subtractor with C/V/Z flags
//
// Processes DIGIT bits per clock, LSB slice first, taking N = WIDTH/DIGIT RUN cycles
// per operation. The result and flags are registered and change only in the DONE cycle.
//
// Parameters:
//   WIDTH  operand/result width in bits (>= 2)
//   DIGIT  bits handled per cycle; WIDTH must be a multiple of DIGIT
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   start  operation request, honoured in IDLE or DONE
//   A, B   operands (two's complement)
//   Op     0 = A+B, 1 = A-B
//   busy   high while RUN slices are being processed
//   done   one-cycle pulse in the cycle S/C/V/Z take the new result
//   S      result
//   C      carry out, or borrow on subtract
//   V      signed overflow
//   Z      result is zero
//
// Build option:
//   ADDSUB_SAT_EN  when defined, S saturates to the signed extreme on overflow
module serial_adder_subtractor #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             C,
    output logic             V,
    output logic             Z
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q, acc_q, s_q;
    logic              op_q, carry_q, c_q, v_q, z_q;
    logic [CW-1:0]     cnt_q;

    logic              accept, last;
    logic [DIGIT-1:0]  a_sl, b_sl;
    logic [DIGIT:0]    slice_sum;
    logic              cin_msb, c_nx, v_nx;
    logic [WIDTH-1:0]  acc_nx, s_fin;

    assign accept = start && (state_q != RUN);
    assign last   = (cnt_q == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? RUN : IDLE;
            RUN:     state_d = last ? DONE : RUN;
            DONE:    state_d = accept ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    // Operands shift right each cycle, so the active slice is always the low DIGIT bits.
    always_comb begin
        a_sl      = a_q[DIGIT-1:0];
        b_sl      = b_q[DIGIT-1:0] ^ {DIGIT{op_q}};
        slice_sum = {1'b0, a_sl} + {1'b0, b_sl} + {{DIGIT{1'b0}}, carry_q};
        // Carry into a bit is recovered from its sum bit and its two inputs.
        cin_msb   = slice_sum[DIGIT-1] ^ a_sl[DIGIT-1] ^ b_sl[DIGIT-1];
        c_nx      = slice_sum[DIGIT] ^ op_q;
        v_nx      = cin_msb ^ slice_sum[DIGIT];
        // New slice enters at the top; after N cycles the LSB slice sits at the bottom.
        acc_nx    = (acc_q >> DIGIT) | (WIDTH'(slice_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
`ifdef ADDSUB_SAT_EN
        // In the final cycle a_sl is the top slice, so its MSB is the sign of A.
        s_fin     = !v_nx ? acc_nx :
                    a_sl[DIGIT-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
        s_fin     = acc_nx;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
        end else if (accept) begin
            a_q     <= A;
            b_q     <= B;
            op_q    <= Op;
            carry_q <= Op;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else if (state_q == RUN) begin
            a_q     <= a_q >> DIGIT;
            b_q     <= b_q >> DIGIT;
            carry_q <= slice_sum[DIGIT];
            cnt_q   <= cnt_q + CW'(1);
            acc_q   <= acc_nx;
            if (last) begin
                s_q <= s_fin;
                c_q <= c_nx;
                v_q <= v_nx;
                z_q <= (s_fin == '0);
            end
        end
    end

    assign S = s_q;
    assign C = c_q;
    assign V = v_q;
    assign Z = z_q;
endmodule

// File: tb/tb_serial_adder_subtractor.sv
// tb_serial_adder_subtractor: directed self-checking bench for serial_adder_subtractor
module tb_serial_adder_subtractor;
    logic        clk = 1'b0;
    logic        rst_n, start, Op;
    logic [15:0] A, B;
    logic        busy, done, C, V, Z;
    logic [15:0] S;
    int          passed = 0;
    int          total = 0;

`ifdef ADDSUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    serial_adder_subtractor #(.WIDTH(16), .DIGIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Op(Op),
        .busy(busy), .done(done), .S(S), .C(C), .V(V), .Z(Z)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_res(input string tag, input logic [15:0] s, input logic c,
                           input logic v, input logic z);
        chk({tag, ".S"}, 32'(S), 32'(s));
        chk({tag, ".C"}, 32'(C), 32'(c));
        chk({tag, ".V"}, 32'(V), 32'(v));
        chk({tag, ".Z"}, 32'(Z), 32'(z));
    endtask

    // Drives start for cycle t; returns in cycle t+1.
    task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic op);
        A = a; B = b; Op = op; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Called in cycle t+1; returns in cycle t+5 (the DONE cycle) after checking it.
    task automatic finish(input string tag, input logic [15:0] s, input logic c,
                          input logic v, input logic z);
        step(); step(); step();
        chk({tag, ".done_t4"}, 32'(done), 32'd0);
        chk({tag, ".busy_t4"}, 32'(busy), 32'd1);
        step();
        chk({tag, ".done_t5"}, 32'(done), 32'd1);
        chk({tag, ".busy_t5"}, 32'(busy), 32'd0);
        chk_res(tag, s, c, v, z);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b1; A = 16'hAAAA; B = 16'h5555; Op = 1'b0;
        step(); step();
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk_res("rst", 16'h0000, 1'b0, 1'b0, 1'b0);
        start = 1'b0; rst_n = 1'b1;
        step();
        chk("idle.busy", 32'(busy), 32'd0);

        // Add overflow
        launch(16'h7FFF, 16'h0001, 1'b0);
        chk("ovf.busy_t1", 32'(busy), 32'd1);
        chk("ovf.hold_S", 32'(S), 32'h0000);
        finish("ovf", SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1, 1'b0);
        step();
        chk("ovf.done_t6", 32'(done), 32'd0);

        // Subtract with borrow; S holds the previous result while running
        launch(16'h0005, 16'h0007, 1'b1);
        chk("borrow.hold_S", 32'(S), SAT ? 32'h7FFF : 32'h8000);
        chk("borrow.hold_V", 32'(V), 32'd1);
        finish("borrow", 16'hFFFE, 1'b1, 1'b0, 1'b0);
        step();

        // Subtract to zero
        launch(16'h1234, 16'h1234, 1'b1);
        finish("zero", 16'h0000, 1'b0, 1'b0, 1'b1);
        step();

        // Start while busy is ignored
        launch(16'h0003, 16'h0004, 1'b0);
        step();
        A = 16'h1111; B = 16'h2222; Op = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("busy_start.done_t4", 32'(done), 32'd0);
        step();
        chk("busy_start.done_t5", 32'(done), 32'd1);
        chk_res("busy_start", 16'h0007, 1'b0, 1'b0, 1'b0);
        step();
        chk("busy_start.done_t6", 32'(done), 32'd0);
        chk("busy_start.busy_t6", 32'(busy), 32'd0);
        step();

        // Reset mid-operation
        launch(16'h0100, 16'h0200, 1'b0);
        step(); step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.done", 32'(done), 32'd0);
        chk_res("midrst", 16'h0000, 1'b0, 1'b0, 1'b0);
        step(); step(); step();
        chk("midrst.no_done", 32'(done), 32'd0);
        chk("midrst.idle", 32'(busy), 32'd0);
        launch(16'h0010, 16'h0020, 1'b0);
        finish("after_rst", 16'h0030, 1'b0, 1'b0, 1'b0);
        step();

        // Back-to-back: second start held in the first DONE cycle
        launch(16'hFFFF, 16'h0001, 1'b0);
        step(); step(); step();
        A = 16'h8000; B = 16'h0001; Op = 1'b1; start = 1'b1;
        step();
        chk("b2b1.done", 32'(done), 32'd1);
        chk_res("b2b1", 16'h0000, 1'b1, 1'b0, 1'b1);
        step();
        start = 1'b0;
        chk("b2b2.busy_t1", 32'(busy), 32'd1);
        chk("b2b2.hold_S", 32'(S), 32'h0000);
        finish("b2b2", SAT ? 16'h8000 : 16'h7FFF, 1'b0, 1'b1, 1'b0);
        step();
        chk("b2b2.done_t6", 32'(done), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/serial_adder_subtractor.md
SERIAL_ADDER_SUBTRACTOR -- requirements
Module: serial_adder_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width in bits, at least 2.
REQ-002 SHALL have parameter DIGIT, default 4: bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT, with N = WIDTH/DIGIT.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all logic rising-edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request an operation, sampled only while accepting.
REQ-006 SHALL have port A, input, WIDTH bits: minuend or first addend, two's complement.
REQ-007 SHALL have port B, input, WIDTH bits: subtrahend or second addend.
REQ-008 SHALL have port Op, input, 1 bit: 0 = A+B, 1 = A-B.
REQ-009 SHALL have port busy, output, 1 bit: operation in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-011 SHALL have port S, output, WIDTH bits: result.
REQ-012 SHALL have ports C, V and Z, each output, 1 bit: carry/borrow flag, signed overflow flag and zero flag.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 SHALL accept a start in IDLE or DONE (accept cycle t), latching A, B and Op, entering RUN and asserting busy from t+1.
REQ-015 SHALL ignore start while in RUN, with no effect on latched operands or outputs.
REQ-016 In RUN, SHALL process one DIGIT-bit slice per cycle, LSB slice first, for exactly N cycles.
REQ-017 SHALL use B XOR Op as the effective B, with carry-in Op on slice 0 and the carry register chaining between slices.
REQ-018 SHALL enter DONE at cycle t+N+1, holding done=1 and busy=0 for that one cycle with S/C/V/Z updated in the same cycle; from DONE, SHALL go to IDLE unless start is accepted.
REQ-019 SHALL define C = (carry out of bit WIDTH-1) XOR Op, so that C=1 means a borrow on subtract.
REQ-020 SHALL define V = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
REQ-021 SHALL define Z = 1 iff the final S == 0.
REQ-022 SHALL hold S/C/V/Z at the previous result during RUN, changing them only in the DONE cycle.
REQ-023 SHALL support back-to-back operation: start accepted in DONE gives a result N+1 cycles later, with no idle gap required.
REQ-024 SHALL give the same result for any DIGIT value that meets REQ-002; DIGIT=WIDTH gives N=1 and latency 2.

Reset
REQ-025 With rst_n=0 at a clock edge, SHALL go to IDLE with busy=0, done=0, S=0, C=0, V=0, Z=0, and clear the internal carry and operands.
REQ-026 On reset during RUN, SHALL abort the operation, produce no done pulse, and leave no partial result visible.
REQ-027 SHALL treat a start asserted in the same cycle as rst_n=0 as ignored.

Configuration
REQ-028 With macro ADDSUB_SAT_EN defined and V=1, SHALL clamp S to 2^(WIDTH-1)-1 if A[WIDTH-1]=0, else to -2^(WIDTH-1).
REQ-029 With ADDSUB_SAT_EN defined, SHALL still report V=1 and C unchanged, and SHALL compute Z on the clamped S.
REQ-030 With ADDSUB_SAT_EN undefined, SHALL wrap S modulo 2^WIDTH with no clamp logic present.

Verification (WIDTH=16, DIGIT=4, N=4)
REQ-031 Add overflow: A=0x7FFF, B=0x0001, Op=0 -> done at t+5, S=0x8000 (0x7FFF with ADDSUB_SAT_EN), C=0, V=1, Z=0.
REQ-032 Subtract with borrow: A=0x0005, B=0x0007, Op=1 -> S=0xFFFE, C=1, V=0, Z=0.
REQ-033 Subtract to zero: A=0x1234, B=0x1234, Op=1 -> S=0x0000, C=0, V=0, Z=1.
REQ-034 Start while busy: start at t+2 with new operands -> ignored, single done at t+5 carrying the original result.
REQ-035 Reset mid-op: rst_n=0 at t+3 -> no done pulse, all outputs 0, IDLE; a new start then completes normally.
REQ-036 Back-to-back: start held high with a second operand pair in the DONE cycle -> second done exactly 5 cycles after the first, with correct results for both.
